sa_autosa_bdma_grp_sched: RTL
=============================

SA_AUTOSA_BDMA_GRP_SCHED -- requirements
Module: sa_autosa_bdma_grp_sched

Interface
REQ-001 SHALL have parameter STALL_CNT_W, default 32, width of the issue-stall counter.
REQ-002 SHALL have a single clock and an asynchronous active-low reset: autosa_core_clk clocks all state; autosa_core_rstn is the reset.
REQ-003 SHALL have port autosa_core_clk  in  1  core clock.
REQ-004 SHALL have port autosa_core_rstn  in  1  async reset, active low.
REQ-005 SHALL have port csb2sched_launch  in  2  per-group launch pulse; bit g = group g.
REQ-006 SHALL have port csb2sched_intr_en  in  2  per-group interrupt enable, sampled on launch.
REQ-007 SHALL have port sched2ld_vld  out  1  issue valid to the load engine.
REQ-008 SHALL have port ld2sched_rdy  in  1  load engine accepts the issue.
REQ-009 SHALL have port sched2ld_grp  out  1  group id being issued.
REQ-010 SHALL have port st2sched_done  in  2  per-group completion pulse from the store engine.
REQ-011 SHALL have port sched2csb_busy  out  2  group g is PEND or RUN.
REQ-012 SHALL have port sched2glb_done_intr_pd  out  2  one-cycle interrupt pulse per group.
REQ-013 SHALL have port sched2csb_err  out  1  sticky protocol error.
REQ-014 SHALL have port csb2sched_err_clr  in  1  clears sched2csb_err.
REQ-015 SHALL have port sched2csb_stall_cnt  out  STALL_CNT_W  saturating issue-stall cycle count.
REQ-016 SHALL have port csb2sched_stall_clr  in  1  clears the stall counter.
REQ-017 SHALL have port sched_idle  out  1  all groups IDLE, order queue empty.
REQ-018 SHALL have port sched2gate_slcg_en  out  1  clock-gate enable (= !sched_idle, registered).

Function
REQ-019 SHALL keep one FSM per group: IDLE -> PEND (launch accepted) -> RUN (issue handshake) -> IDLE (done).
REQ-020 SHALL keep a 2-entry order FIFO of group ids; push on accepted launch, pop on vld&&rdy; issue order = launch order.
REQ-021 SHALL accept a launch only when the group is IDLE, or when it is RUN with its done in the same cycle; otherwise ignore the launch and set err.
REQ-022 SHALL push group 0 before group 1 when both launch in the same cycle.
REQ-023 SHALL register sched2ld_vld/sched2ld_grp; vld asserts the cycle after the head entry becomes PEND (launch N -> vld N+1).
REQ-024 SHALL hold vld and grp stable until ld2sched_rdy; no withdrawal; after a handshake, a queued next entry gives vld in the following cycle (one bubble).
REQ-025 SHALL allow both groups in RUN simultaneously.
REQ-026 SHALL move a group RUN -> IDLE on st2sched_done[g]; a done on a non-RUN group SHALL be ignored and set err.
REQ-027 SHALL pulse sched2glb_done_intr_pd[g] for one cycle, one cycle after an accepted done, if intr_en latched at launch was 1.
REQ-028 SHALL increment the stall counter on each cycle with vld && !rdy, saturate at all-ones, and give clear priority over increment.
REQ-029 SHALL set err on any violation; err stays set until csb2sched_err_clr; a same-cycle set wins over clear.
REQ-030 SHALL drive sched2csb_busy combinationally from the FSM states; sched_idle and slcg_en SHALL be registered.

Reset
REQ-031 SHALL asynchronously reset all FSMs to IDLE, FIFO to empty, vld/grp/intr/err/stall_cnt to 0, sched_idle to 1, slcg_en to 0.
REQ-032 SHALL discard in-flight groups on reset mid-operation; a done arriving after reset SHALL set err.

Verification
REQ-033 Single launch: launch=01, intr_en=01, rdy=1 -> vld=1 grp=0 next cycle; done=01 later -> intr=01 one cycle later; idle=1.
REQ-034 Dual launch: launch=11 same cycle, rdy=1 -> issues grp0 then grp1 with one bubble; busy=11 until both dones.
REQ-035 Backpressure: rdy=0 for 5 cycles with vld=1 -> grp stable, stall_cnt=5; stall_clr -> 0.
REQ-036 Errors: relaunch grp0 while PEND -> err=1, no second issue; done=10 with grp1 IDLE -> err=1; err_clr -> 0.
REQ-037 Relaunch on done: grp0 RUN, done=01 and launch=01 same cycle -> intr pulse, grp0 PEND, reissued.
REQ-038 Reset mid-run: assert rstn low with grp1 RUN -> all outputs at reset values immediately; later done=10 -> err=1.

Source files
------------

// File: rtl/sa_autosa_bdma_grp_sched.sv
// -----------------------------------------------------------------------------
// sa_autosa_bdma_grp_sched
//
// Schedules two DMA groups onto a single load engine. Each group runs its own
// IDLE -> PEND -> RUN -> IDLE lifecycle. A 2-entry order FIFO holds pending
// group ids so that issues go out in launch order. Completions from the store
// engine retire groups and optionally raise a one-cycle interrupt.
//
// Ports
//   autosa_core_clk         in   core clock
//   autosa_core_rstn        in   asynchronous reset, active low
//   csb2sched_launch[1:0]   in   per-group launch pulse
//   csb2sched_intr_en[1:0]  in   per-group interrupt enable, captured on launch
//   sched2ld_vld            out  issue valid to the load engine (registered)
//   ld2sched_rdy            in   load engine accepts the issue
//   sched2ld_grp            out  group id being issued (registered)
//   st2sched_done[1:0]      in   per-group completion pulse
//   sched2csb_busy[1:0]     out  group is PEND or RUN (combinational)
//   sched2glb_done_intr_pd  out  one-cycle completion interrupt per group
//   sched2csb_err           out  sticky protocol error
//   csb2sched_err_clr       in   clears the error flag
//   sched2csb_stall_cnt     out  saturating count of vld && !rdy cycles
//   csb2sched_stall_clr     in   clears the stall counter
//   sched_idle              out  all groups IDLE and order FIFO empty
//   sched2gate_slcg_en      out  clock-gate enable, inverse of sched_idle
// -----------------------------------------------------------------------------
module sa_autosa_bdma_grp_sched #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   autosa_core_clk,
  input  logic                   autosa_core_rstn,
  input  logic [1:0]             csb2sched_launch,
  input  logic [1:0]             csb2sched_intr_en,
  output logic                   sched2ld_vld,
  input  logic                   ld2sched_rdy,
  output logic                   sched2ld_grp,
  input  logic [1:0]             st2sched_done,
  output logic [1:0]             sched2csb_busy,
  output logic [1:0]             sched2glb_done_intr_pd,
  output logic                   sched2csb_err,
  input  logic                   csb2sched_err_clr,
  output logic [STALL_CNT_W-1:0] sched2csb_stall_cnt,
  input  logic                   csb2sched_stall_clr,
  output logic                   sched_idle,
  output logic                   sched2gate_slcg_en
);

  typedef enum logic [1:0] {
    GRP_IDLE = 2'd0,
    GRP_PEND = 2'd1,
    GRP_RUN  = 2'd2
  } grp_state_t;

  logic [1:0]             launch_ok, launch_bad, done_ok, done_bad;
  logic [1:0]             issue_hit, is_idle_next, intr_next;
  logic                   handshake;
  logic                   vld_reg, vld_next, grp_reg, grp_next;
  logic [1:0]             q_reg, q_next;      // bit i = group id in slot i
  logic [1:0]             cnt_reg, cnt_next;
  logic [1:0]             intr_reg;
  logic                   err_reg, err_next;
  logic [STALL_CNT_W-1:0] stall_reg, stall_next;
  logic                   idle_reg, idle_next, slcg_reg;

  assign handshake = vld_reg & ld2sched_rdy;

  // Per-group lifecycle FSM
  for (genvar gi = 0; gi < 2; gi++) begin : g_grp
    grp_state_t state_reg, state_next;
    logic       intr_en_reg;
    logic       is_idle, is_run;

    assign is_idle            = (state_reg == GRP_IDLE);
    assign is_run             = (state_reg == GRP_RUN);
    assign sched2csb_busy[gi] = ~is_idle;
    assign done_ok[gi]        = st2sched_done[gi] & is_run;
    assign done_bad[gi]       = st2sched_done[gi] & ~is_run;
    // A RUN group completing this cycle may be relaunched in the same cycle.
    assign launch_ok[gi]      = csb2sched_launch[gi] & (is_idle | done_ok[gi]);
    assign launch_bad[gi]     = csb2sched_launch[gi] & ~launch_ok[gi];
    assign issue_hit[gi]      = handshake & (grp_reg == 1'(gi));
    // Interrupt uses the enable captured by the launch that is now completing.
    assign intr_next[gi]      = done_ok[gi] & intr_en_reg;
    assign is_idle_next[gi]   = (state_next == GRP_IDLE);

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        GRP_IDLE: if (launch_ok[gi]) state_next = GRP_PEND;
        GRP_PEND: if (issue_hit[gi]) state_next = GRP_RUN;
        GRP_RUN: begin
          if (launch_ok[gi])      state_next = GRP_PEND;
          else if (done_ok[gi])   state_next = GRP_IDLE;
        end
        default: state_next = GRP_IDLE;
      endcase
    end

    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
      if (!autosa_core_rstn) begin
        state_reg   <= GRP_IDLE;
        intr_en_reg <= 1'b0;
      end else begin
        state_reg <= state_next;
        if (launch_ok[gi]) intr_en_reg <= csb2sched_intr_en[gi];
      end
    end
  end

  // Order FIFO. Its occupancy always equals the number of PEND groups, so it
  // can never exceed two entries. Pop first, then append group 0 before 1.
  always_comb begin
    q_next   = q_reg;
    cnt_next = cnt_reg;
    if (handshake) begin
      q_next[0] = q_reg[1];
      cnt_next  = cnt_reg - 2'd1;
    end
    for (int i = 0; i < 2; i++) begin
      if (launch_ok[i]) begin
        if (cnt_next == 2'd0) q_next[0] = 1'(i);
        else                  q_next[1] = 1'(i);
        cnt_next = cnt_next + 2'd1;
      end
    end
  end

  // Issue register: hold under backpressure, drop for one bubble after a
  // handshake, otherwise present the FIFO head as soon as it exists.
  always_comb begin
    vld_next = vld_reg;
    grp_next = grp_reg;
    if (handshake) begin
      vld_next = 1'b0;
    end else if (!vld_reg && (cnt_next != 2'd0)) begin
      vld_next = 1'b1;
      grp_next = q_next[0];
    end
  end

  // Error: a new violation beats a same-cycle clear.
  always_comb begin
    err_next = err_reg;
    if ((|launch_bad) || (|done_bad)) err_next = 1'b1;
    else if (csb2sched_err_clr)       err_next = 1'b0;
  end

  always_comb begin
    stall_next = stall_reg;
    if (csb2sched_stall_clr)
      stall_next = '0;
    else if (vld_reg && !ld2sched_rdy && !(&stall_reg))
      stall_next = stall_reg + STALL_CNT_W'(1);
  end

  // Registered from next-state values so the flag tracks the current state.
  assign idle_next = (&is_idle_next) & (cnt_next == 2'd0);

  always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
    if (!autosa_core_rstn) begin
      vld_reg   <= 1'b0;
      grp_reg   <= 1'b0;
      q_reg     <= 2'b00;
      cnt_reg   <= 2'd0;
      intr_reg  <= 2'b00;
      err_reg   <= 1'b0;
      stall_reg <= '0;
      idle_reg  <= 1'b1;
      slcg_reg  <= 1'b0;
    end else begin
      vld_reg   <= vld_next;
      grp_reg   <= grp_next;
      q_reg     <= q_next;
      cnt_reg   <= cnt_next;
      intr_reg  <= intr_next;
      err_reg   <= err_next;
      stall_reg <= stall_next;
      idle_reg  <= idle_next;
      slcg_reg  <= ~idle_next;
    end
  end

  assign sched2ld_vld           = vld_reg;
  assign sched2ld_grp           = grp_reg;
  assign sched2glb_done_intr_pd = intr_reg;
  assign sched2csb_err          = err_reg;
  assign sched2csb_stall_cnt    = stall_reg;
  assign sched_idle             = idle_reg;
  assign sched2gate_slcg_en     = slcg_reg;

endmodule
